// File: rtl/ks_pkg.sv
// Shared sizing helpers for the pipelined Kogge-Stone adder.
package ks_pkg;

  // Ceiling log2 that is usable in constant expressions.
  function automatic int ks_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  // Number of prefix-register stages: one register per REG_EVERY levels,
  // with a partial last group still getting its own register.
  function automatic int ks_nstage(input int width, input int reg_every);
    return (ks_clog2(width) + reg_every - 1) / reg_every;
  endfunction

  // Accept-edge to out_valid latency: prefix stages plus the output register.
  function automatic int ks_lat(input int width, input int reg_every);
    return ks_nstage(width, reg_every) + 1;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix row: black cells combine with the
// position DIST below, positions below DIST pass straight through.
module ks_prefix_level #(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_g,
  output logic [WIDTH-1:0] o_p
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_cell
      assign o_g[i] = i_g[i] | (i_p[i] & i_g[i-DIST]);
      assign o_p[i] = i_p[i] & i_p[i-DIST];
    end else begin : g_pass
      assign o_g[i] = i_g[i];
      assign o_p[i] = i_p[i];
    end
  end

endmodule

// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with tag sideband and a single
// global stall enable (no bubble collapse).
module kogge_stone_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG2W  = ks_clog2(WIDTH);
  localparam int NSTAGE = ks_nstage(WIDTH, REG_EVERY);

  // One pipeline slot: the op's valid and tag, the conditioned carry-in,
  // the bit-level propagate (needed for the final sum) and the group G/P.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             c0;
    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] g_grp;
    logic [WIDTH-1:0] p_grp;
  } stage_t;

  stage_t r_st  [NSTAGE+1];
  stage_t w_nxt [NSTAGE+1];

  logic [WIDTH-1:0] w_gi [LOG2W];
  logic [WIDTH-1:0] w_pi [LOG2W];
  logic [WIDTH-1:0] w_go [LOG2W];
  logic [WIDTH-1:0] w_po [LOG2W];

  logic             w_en;
  logic [WIDTH-1:0] w_bx, w_gbit, w_pbit, w_g0;
  logic             w_c0;
  logic [WIDTH-1:0] w_carry, w_sum;
  logic             w_cout, w_ovf;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf;
  logic [TAG_W-1:0] r_tag;

  // Every stage moves together whenever the output slot is empty or draining.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // Operand conditioning: subtract is A + ~B + ~cin.
  assign w_bx   = b ^ {WIDTH{sub}};
  assign w_c0   = cin ^ sub;
  assign w_gbit = a & w_bx;
  assign w_pbit = a ^ w_bx;
  // Carry-in is treated as a generate below bit 0, so G[i] becomes the true
  // carry out of bit i once the tree has finished.
  assign w_g0   = w_gbit | {{(WIDTH-1){1'b0}}, w_pbit[0] & w_c0};

  assign w_nxt[0] = '{valid: in_valid, tag: tag, c0: w_c0,
                      p_bit: w_pbit, g_grp: w_g0, p_grp: w_pbit};

  // Prefix levels; a level reads from a register at each group boundary and
  // from the previous level's wires otherwise.
  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    if (k % REG_EVERY == 0) begin : g_from_reg
      assign w_gi[k] = r_st[k/REG_EVERY].g_grp;
      assign w_pi[k] = r_st[k/REG_EVERY].p_grp;
    end else begin : g_chain
      assign w_gi[k] = w_go[k-1];
      assign w_pi[k] = w_po[k-1];
    end
    ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
      .i_g (w_gi[k]),
      .i_p (w_pi[k]),
      .o_g (w_go[k]),
      .o_p (w_po[k])
    );
  end

  // Stage s captures the last level of its group (last group may be short).
  for (genvar s = 1; s <= NSTAGE; s++) begin : g_stg
    localparam int LAST = ((s * REG_EVERY < LOG2W) ? s * REG_EVERY : LOG2W) - 1;
    assign w_nxt[s] = '{valid: r_st[s-1].valid, tag: r_st[s-1].tag,
                        c0: r_st[s-1].c0, p_bit: r_st[s-1].p_bit,
                        g_grp: w_go[LAST], p_grp: w_po[LAST]};
  end

  // Stage registers: flush on reset, otherwise advance all slots on enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= NSTAGE; s++) r_st[s] <= '0;
    end else if (w_en) begin
      for (int s = 0; s <= NSTAGE; s++) r_st[s] <= w_nxt[s];
    end
  end

  // Result formation from the last prefix register.
  assign w_carry = {r_st[NSTAGE].g_grp[WIDTH-2:0], r_st[NSTAGE].c0};
  assign w_sum   = r_st[NSTAGE].p_bit ^ w_carry;
  assign w_cout  = r_st[NSTAGE].g_grp[WIDTH-1];
  assign w_ovf   = w_carry[WIDTH-1] ^ w_cout;

  // Output register: refilled in the same cycle it is drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_tag       <= '0;
    end else if (w_en) begin
      r_out_valid <= r_st[NSTAGE].valid;
      if (r_st[NSTAGE].valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_tag  <= r_st[NSTAGE].tag;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_tag   = r_tag;

endmodule
